// File: rtl/bcd_seq_mult.sv
// bcd_seq_mult: sequential packed-BCD multiplier, one BCD addition per clock; done after DIGITS+sum(y digits)+1 cycles.
// start is honoured only in IDLE; requests arriving while busy or finishing are dropped, never queued.
module bcd_seq_mult #(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   x,
    input  logic [4*DIGITS-1:0]   y,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [8*DIGITS-1:0]   product
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = 8 * DIGITS;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_ADD, S_FIN} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [4*DIGITS-1:0] r_x_cap;
    logic [4*DIGITS-1:0] r_y_cap;
    logic [PW-1:0]       r_acc;
    logic [3:0]          r_cnt;
    logic [IW-1:0]       r_idx;
    logic                r_err_pending;
    logic                r_busy;
    logic                r_done;
    logic                r_error;
    logic [PW-1:0]       r_product;

    logic                w_in_bad;
    logic [3:0]          w_ydig;
    logic [3:0]          w_cnt_dec;
    logic [PW-1:0]       w_acc_sum;
    logic                w_busy_nxt;
    logic                w_done_nxt;
    logic                w_error_nxt;
    logic [PW-1:0]       w_product_nxt;

    function automatic logic has_bad_digit(input logic [4*DIGITS-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    // Ripple decimal add; the final carry is dropped since the product always fits.
    function automatic logic [PW-1:0] bcd_add(input logic [PW-1:0] a, input logic [PW-1:0] b);
        logic [PW-1:0] s;
        logic          c;
        logic [4:0]    d;
        s = '0;
        c = 1'b0;
        for (int i = 0; i < 2*DIGITS; i++) begin
            d = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, c};
            if (d > 5'd9) begin
                d = d + 5'd6;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            s[4*i +: 4] = d[3:0];
        end
        return s;
    endfunction

    assign w_in_bad  = has_bad_digit(x) | has_bad_digit(y);
    assign w_cnt_dec = r_cnt - 4'd1;
    assign w_acc_sum = bcd_add(r_acc, {{(4*DIGITS){1'b0}}, r_x_cap});

    always_comb begin
        w_ydig = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IW'(i)) w_ydig = r_y_cap[4*i +: 4];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = w_in_bad ? S_FIN : S_SHIFT;
            end
            S_SHIFT: begin
                if (w_ydig != 4'd0)    w_state_nxt = S_ADD;
                else if (r_idx == '0)  w_state_nxt = S_FIN;
            end
            S_ADD: begin
                if (w_cnt_dec == 4'd0) w_state_nxt = (r_idx == '0) ? S_FIN : S_SHIFT;
            end
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Multiplier digits are walked from the most significant down, one shift per digit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x_cap       <= '0;
            r_y_cap       <= '0;
            r_acc         <= '0;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_err_pending <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x_cap       <= x;
                        r_y_cap       <= y;
                        r_err_pending <= w_in_bad;
                        if (!w_in_bad) begin
                            r_acc <= '0;
                            r_idx <= IW'(DIGITS - 1);
                        end
                    end
                end
                S_SHIFT: begin
                    r_acc <= {r_acc[PW-5:0], 4'h0};
                    r_cnt <= w_ydig;
                    if (w_ydig == 4'd0 && r_idx != '0) r_idx <= r_idx - IW'(1);
                end
                S_ADD: begin
                    r_acc <= w_acc_sum;
                    r_cnt <= w_cnt_dec;
                    if (w_cnt_dec == 4'd0 && r_idx != '0) r_idx <= r_idx - IW'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_busy_nxt    = (r_state == S_SHIFT) || (r_state == S_ADD);
        w_done_nxt    = (r_state == S_FIN);
        w_error_nxt   = r_error;
        w_product_nxt = r_product;
        case (r_state)
            S_SHIFT, S_ADD: w_error_nxt = 1'b0;
            S_FIN: begin
                w_error_nxt   = r_err_pending;
                w_product_nxt = r_err_pending ? '0 : r_acc;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_product <= '0;
        end else begin
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_error   <= w_error_nxt;
            r_product <= w_product_nxt;
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign error   = r_error;
    assign product = r_product;

endmodule

// File: tb/tb_bcd_seq_mult.sv
// Bench for bcd_seq_mult at DIGITS=2 and DIGITS=1, checked cycle by cycle against an arithmetic reference.
module tb_bcd_seq_mult;

    logic        clk = 1'b0;
    logic        reset;
    logic        start2, start1;
    logic [7:0]  x2, y2;
    logic [3:0]  x1, y1;
    logic        busy2, done2, err2;
    logic        busy1, done1, err1;
    logic [15:0] prod2;
    logic [7:0]  prod1;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    bcd_seq_mult #(.DIGITS(2)) u_d2 (
        .clk(clk), .reset(reset), .start(start2), .x(x2), .y(y2),
        .busy(busy2), .done(done2), .error(err2), .product(prod2)
    );

    bcd_seq_mult #(.DIGITS(1)) u_d1 (
        .clk(clk), .reset(reset), .start(start1), .x(x1), .y(y1),
        .busy(busy1), .done(done1), .error(err1), .product(prod1)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int bcd_val(input logic [7:0] v, input int d);
        int n = 0;
        for (int i = d - 1; i >= 0; i--) n = n * 10 + int'(v[4*i +: 4]);
        return n;
    endfunction

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(n % 10);
            n = n / 10;
        end
        return r;
    endfunction

    function automatic bit bad(input logic [7:0] v, input int d);
        for (int i = 0; i < d; i++) if (v[4*i +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    task automatic set_in(input int sel, input logic [7:0] xa, input logic [7:0] ya, input logic s);
        if (sel == 2) begin
            x2 = xa; y2 = ya; start2 = s;
        end else begin
            x1 = xa[3:0]; y1 = ya[3:0]; start1 = s;
        end
    endtask

    task automatic sample(input int sel, output logic b, output logic dn, output logic e, output logic [15:0] p);
        if (sel == 2) begin
            b = busy2; dn = done2; e = err2; p = prod2;
        end else begin
            b = busy1; dn = done1; e = err1; p = {8'h00, prod1};
        end
    endtask

    // sel is also the digit count of the targeted instance; glitch = cycle offset of a stray start.
    task automatic run(input int sel, input logic [7:0] xa, input logic [7:0] ya, input int glitch);
        bit          inv;
        int          s, lat;
        logic [15:0] ep, p;
        logic        b, dn, e;
        string       t;
        inv = bad(xa, sel) || bad(ya, sel);
        s = 0;
        for (int i = 0; i < sel; i++) s += int'(ya[4*i +: 4]);
        lat = inv ? 1 : sel + s + 1;
        ep  = inv ? 16'h0 : to_bcd(bcd_val(xa, sel) * bcd_val(ya, sel));
        @(negedge clk);
        set_in(sel, xa, ya, 1'b1);
        @(posedge clk);
        #1 set_in(sel, xa, ya, 1'b0);
        for (int c = 1; c <= lat + 1; c++) begin
            if (c == glitch) set_in(sel, 8'h99, 8'h99, 1'b1);
            @(posedge clk);
            #1;
            if (c == glitch) set_in(sel, 8'h99, 8'h99, 1'b0);
            sample(sel, b, dn, e, p);
            t = $sformatf("D%0d %h*%h c%0d", sel, xa, ya, c);
            chk({t, " busy"},  {15'b0, b},  {15'b0, (!inv && c <= lat - 1)});
            chk({t, " done"},  {15'b0, dn}, {15'b0, (c == lat)});
            chk({t, " error"}, {15'b0, e},  {15'b0, inv});
            if (c >= lat) chk({t, " product"}, p, ep);
        end
    endtask

    function automatic logic [7:0] rand_operand(input int d);
        logic [7:0] v;
        v = to_bcd(int'($urandom_range(0, (d == 2) ? 99 : 9)))[7:0];
        if ($urandom_range(0, 7) == 0) v[4*$urandom_range(0, d - 1) +: 4] = 4'($urandom_range(10, 15));
        return v;
    endfunction

    initial begin
        logic        b, dn, e;
        logic [15:0] p;
        reset = 1'b1;
        set_in(2, 8'h00, 8'h00, 1'b0);
        set_in(1, 8'h00, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        for (int sel = 1; sel <= 2; sel++) begin
            sample(sel, b, dn, e, p);
            chk($sformatf("reset D%0d busy", sel),    {15'b0, b},  16'h0);
            chk($sformatf("reset D%0d done", sel),    {15'b0, dn}, 16'h0);
            chk($sformatf("reset D%0d error", sel),   {15'b0, e},  16'h0);
            chk($sformatf("reset D%0d product", sel), p,           16'h0);
        end
        @(negedge clk);
        reset = 1'b0;

        run(2, 8'h12, 8'h34, 0);
        run(2, 8'h99, 8'h99, 0);
        run(2, 8'h05, 8'h00, 0);
        run(2, 8'h1A, 8'h03, 0);
        run(2, 8'h02, 8'h04, 0);
        run(2, 8'h12, 8'h34, 3);
        run(2, 8'h12, 8'h34, 10);

        // Abort a request with reset mid-way; no done may follow.
        @(negedge clk);
        set_in(2, 8'h12, 8'h34, 1'b1);
        @(posedge clk);
        #1 set_in(2, 8'h12, 8'h34, 1'b0);
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        sample(2, b, dn, e, p);
        chk("abort busy",    {15'b0, b},  16'h0);
        chk("abort done",    {15'b0, dn}, 16'h0);
        chk("abort error",   {15'b0, e},  16'h0);
        chk("abort product", p,           16'h0);
        reset = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            #1;
            sample(2, b, dn, e, p);
            chk($sformatf("post-abort c%0d done", c), {15'b0, dn}, 16'h0);
            chk($sformatf("post-abort c%0d busy", c), {15'b0, b},  16'h0);
        end

        run(1, 8'h03, 8'h02, 0);
        run(1, 8'h01, 8'h00, 0);
        run(1, 8'h05, 8'h04, 0);
        run(1, 8'h09, 8'h09, 0);
        run(1, 8'h08, 8'h07, 0);
        run(1, 8'h04, 8'h02, 0);
        run(1, 8'h02, 8'h04, 0);
        run(1, 8'h0A, 8'h00, 0);

        for (int n = 0; n < 40; n++) run(2, rand_operand(2), rand_operand(2), 0);
        for (int n = 0; n < 25; n++) run(1, rand_operand(1), rand_operand(1), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
